instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the byte address of the first fetched instruction after reset.
REQ-002 The module SHALL have parameter PC_STEP, default 4, meaning the byte increment applied per accepted instruction.
REQ-003 Port clock  input  1  meaning the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  meaning the reset; reset SHALL be synchronous and active-high.
REQ-005 Port imem_addr  output  32  meaning the word index driven to instruction memory, equal to {2'b00, pc[31:2]}.
REQ-006 Port imem_instr  input  32  meaning the instruction word returned combinationally for imem_addr in the same cycle.
REQ-007 Port redirect_valid  input  1  meaning a branch or jump redirect request.
REQ-008 Port redirect_pc  input  32  meaning the redirect target byte address.
REQ-009 Port out_valid  output  1  meaning out_pc and out_instr hold a valid fetched instruction.
REQ-010 Port out_ready  input  1  meaning the decode stage accepts the current output this cycle.
REQ-011 Port out_pc  output  32  meaning the byte address of out_instr.
REQ-012 Port out_instr  output  32  meaning the registered fetched instruction.
REQ-013 Port fault  output  1  meaning a misaligned redirect was detected; the port SHALL be sticky.

Function
REQ-014 The block SHALL implement three states: IDLE, RUN and FAULT.
REQ-015 The internal pc register SHALL drive imem_addr combinationally; there SHALL be no other path to memory.
REQ-016 In IDLE the block SHALL fetch nothing, keep out_valid=0 and pc=RESET_PC, and move to RUN on the next edge.
REQ-017 In RUN, when out_valid=0 or out_ready=1, the block SHALL load out_instr<=imem_instr, out_pc<=pc, out_valid<=1 and pc<=pc+PC_STEP.
REQ-018 In RUN, when out_valid=1 and out_ready=0 (stall), pc, out_pc, out_instr and out_valid SHALL hold.
REQ-019 Fetch latency SHALL be one cycle: the instruction at pc appears on out_instr the edge after pc is presented.
REQ-020 When redirect_valid=1 in RUN, the block SHALL set pc<=redirect_pc and out_valid<=0 on that edge, overriding both the fetch and the stall.
REQ-021 The output accepted in the same cycle as a redirect SHALL count as consumed; the block SHALL NOT replay it.
REQ-022 pc arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 SHALL wrap to 32'h0000_0000 with no flag.
REQ-023 A redirect in IDLE SHALL be ignored.
REQ-024 FAULT SHALL exist only when the macro is defined; in FAULT, out_valid=0, pc holds, and redirects are ignored until reset.

Reset
REQ-025 Reset SHALL take priority over every other input in every state.
REQ-026 On reset the block SHALL set state=IDLE, pc=RESET_PC, out_valid=0, out_pc=0, out_instr=0 and fault=0.
REQ-027 Reset asserted mid-stall or mid-redirect SHALL discard the pending output and the redirect.

Configuration
REQ-028 The macro FETCH_MISALIGN_TRAP_EN SHALL control misaligned-redirect handling.
REQ-029 With FETCH_MISALIGN_TRAP_EN defined, a redirect with redirect_pc[1:0]!=0 SHALL set fault<=1, out_valid<=0 and state<=FAULT, leaving pc unchanged.
REQ-030 Without FETCH_MISALIGN_TRAP_EN, redirect_pc[1:0] SHALL be forced to 2'b00, fault SHALL be tied to 0, and FAULT SHALL be unreachable.

Verification
REQ-031 Scenario: reset with memory words 0..3 = 0, 00A200B3, 40A200B3, 00A240B3, and out_ready=1 -> out_valid rises in the 2nd cycle after reset with out_pc=0, out_instr=0, followed by pc 4, 8, 12 carrying 00A200B3, 40A200B3, 00A240B3.
REQ-032 Scenario: out_ready=0 for 3 cycles while out_pc=4 -> out_pc=4, out_instr=00A200B3 and imem_addr=2 are held, then advance one instruction per cycle once out_ready=1.
REQ-033 Scenario: redirect_valid=1 with redirect_pc=12 while stalled -> out_valid=0 the next cycle, then out_pc=12 with out_instr=00A240B3.
REQ-034 Scenario: RESET_PC=32'hFFFF_FFFC -> out_pc sequence FFFF_FFFC, 0000_0000 and imem_addr wraps to 0.
REQ-035 Scenario: redirect_pc=6 with the macro defined -> fault=1 and out_valid=0 until reset; without the macro -> next out_pc=4.
REQ-036 Scenario: reset asserted while out_valid=1 and out_ready=0 -> out_valid=0 and pc=RESET_PC the next cycle.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage with a one-cycle registered output, decode back-pressure and redirects.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects enter a sticky FAULT state until reset.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fault
);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {StIdle, StRun, StFault} state_e;
`else
    typedef enum logic [1:0] {StIdle, StRun} state_e;
`endif

    state_e      state_q;
    logic [31:0] pc_q;
    logic        out_valid_q;
    logic [31:0] out_pc_q;
    logic [31:0] out_instr_q;

    logic        fetch_en;
    logic [31:0] pc_inc;
    logic [31:0] redirect_tgt;

    assign fetch_en  = !out_valid_q || out_ready;
    assign pc_inc    = pc_q + 32'(PC_STEP);
    assign imem_addr = {2'b00, pc_q[31:2]};

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q;
    logic misaligned;

    assign misaligned   = |redirect_pc[1:0];
    assign redirect_tgt = redirect_pc;
    assign fault        = fault_q;
`else
    // Low bits are dropped so a misaligned target lands on its containing word.
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign fault        = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_pc_q    <= 32'h0;
            out_instr_q <= 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q     <= StRun;
                    pc_q        <= RESET_PC;
                    out_valid_q <= 1'b0;
                end
                StRun: begin
                    if (redirect_valid) begin
                        // Redirect wins over fetch and stall; an output accepted now is not replayed.
                        out_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            fault_q <= 1'b1;
                            state_q <= StFault;
                        end else begin
                            pc_q <= redirect_tgt;
                        end
`else
                        pc_q <= redirect_tgt;
`endif
                    end else if (fetch_en) begin
                        out_instr_q <= imem_instr;
                        out_pc_q    <= pc_q;
                        out_valid_q <= 1'b1;
                        pc_q        <= pc_inc;
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                StFault: begin
                    out_valid_q <= 1'b0;
                end
`endif
                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus random stimulus against a reference model.
// Two instances: default RESET_PC, and RESET_PC = FFFF_FFFC for the wrap-around case.
module tb_instr_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;
    logic        rv_none = 1'b0;
    logic [31:0] rpc_none = 32'h0;

    logic [31:0] imem_addr_a, imem_instr_a, out_pc_a, out_instr_a;
    logic        out_valid_a, fault_a;
    logic [31:0] imem_addr_w, imem_instr_w, out_pc_w, out_instr_w;
    logic        out_valid_w, fault_w;

    logic [31:0] mem [0:255];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    assign imem_instr_a = mem[imem_addr_a[7:0]];
    assign imem_instr_w = mem[imem_addr_w[7:0]];

    instr_fetch u_dut (
        .clock          (clock),
        .reset          (reset),
        .imem_addr      (imem_addr_a),
        .imem_instr     (imem_instr_a),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid_a),
        .out_ready      (out_ready),
        .out_pc         (out_pc_a),
        .out_instr      (out_instr_a),
        .fault          (fault_a)
    );

    instr_fetch #(
        .RESET_PC (32'hFFFF_FFFC)
    ) u_dut_wrap (
        .clock          (clock),
        .reset          (reset),
        .imem_addr      (imem_addr_w),
        .imem_instr     (imem_instr_w),
        .redirect_valid (rv_none),
        .redirect_pc    (rpc_none),
        .out_valid      (out_valid_w),
        .out_ready      (out_ready),
        .out_pc         (out_pc_w),
        .out_instr      (out_instr_w),
        .fault          (fault_w)
    );

    // Reference model: what the fetch stage is showing, expressed as plain values.
    typedef struct packed {
        logic        started;
        logic        trapped;
        logic [31:0] next_pc;
        logic        shown;
        logic [31:0] shown_pc;
        logic [31:0] shown_instr;
    } mdl_t;

    mdl_t m_a, m_w;

    function automatic logic [31:0] mem_word(logic [31:0] byte_addr);
        logic [31:0] idx;
        idx = byte_addr / 4;
        return mem[idx % 256];
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, logic [31:0] start_pc, logic rst, logic rv,
                                      logic [31:0] rpc, logic rdy);
        mdl_t n;
        n = m;
        if (rst) begin
            n         = '0;
            n.next_pc = start_pc;
        end else if (!m.started) begin
            n.started = 1'b1;
            n.next_pc = start_pc;
        end else if (m.trapped) begin
            n.shown = 1'b0;
        end else if (rv) begin
            n.shown = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (rpc % 4 != 0) n.trapped = 1'b1;
            else n.next_pc = rpc;
`else
            n.next_pc = rpc - (rpc % 4);
`endif
        end else if (!m.shown || rdy) begin
            n.shown       = 1'b1;
            n.shown_pc    = m.next_pc;
            n.shown_instr = mem_word(m.next_pc);
            n.next_pc     = m.next_pc + 32'd4;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        check("a.valid", {31'b0, out_valid_a}, {31'b0, m_a.shown});
        check("a.fault", {31'b0, fault_a}, {31'b0, m_a.trapped});
        check("a.imem_addr", imem_addr_a, m_a.next_pc / 4);
        check("a.pc", out_pc_a, m_a.shown_pc);
        check("a.instr", out_instr_a, m_a.shown_instr);
        check("w.valid", {31'b0, out_valid_w}, {31'b0, m_w.shown});
        check("w.fault", {31'b0, fault_w}, 32'h0);
        check("w.imem_addr", imem_addr_w, m_w.next_pc / 4);
        check("w.pc", out_pc_w, m_w.shown_pc);
        check("w.instr", out_instr_w, m_w.shown_instr);
    endtask

    task automatic tick();
        @(posedge clock);
        m_a = mdl_step(m_a, 32'h0, reset, redirect_valid, redirect_pc, out_ready);
        m_w = mdl_step(m_w, 32'hFFFF_FFFC, reset, 1'b0, 32'h0, out_ready);
        @(negedge clock);
        compare_all();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_0000;
        mem[1] = 32'h00A2_00B3;
        mem[2] = 32'h40A2_00B3;
        mem[3] = 32'h00A2_40B3;
        m_a = '0;
        m_w = '0;

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        tick();
        tick();
        check("rst.valid", {31'b0, out_valid_a}, 32'h0);
        check("rst.pc", out_pc_a, 32'h0);
        check("rst.instr", out_instr_a, 32'h0);
        check("rst.fault", {31'b0, fault_a}, 32'h0);
        check("rst.imem_addr", imem_addr_a, 32'h0);

        // Startup sequence and PC wrap on the second instance.
        reset = 1'b0;
        tick();
        check("s31.idle_valid", {31'b0, out_valid_a}, 32'h0);
        check("wrap.imem_addr0", imem_addr_w, 32'h3FFF_FFFF);
        tick();
        check("s31.valid0", {31'b0, out_valid_a}, 32'h1);
        check("s31.pc0", out_pc_a, 32'h0);
        check("s31.instr0", out_instr_a, 32'h0);
        check("wrap.pc0", out_pc_w, 32'hFFFF_FFFC);
        check("wrap.imem_addr1", imem_addr_w, 32'h0);
        tick();
        check("s31.pc4", out_pc_a, 32'h4);
        check("s31.instr4", out_instr_a, 32'h00A2_00B3);
        check("wrap.pc1", out_pc_w, 32'h0);

        // Stall for three cycles while showing pc 4.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s32.hold_pc", out_pc_a, 32'h4);
            check("s32.hold_instr", out_instr_a, 32'h00A2_00B3);
            check("s32.hold_addr", imem_addr_a, 32'h2);
        end
        out_ready = 1'b1;
        tick();
        check("s32.pc8", out_pc_a, 32'h8);
        check("s32.instr8", out_instr_a, 32'h40A2_00B3);

        // Redirect while stalled.
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd12;
        tick();
        check("s33.bubble", {31'b0, out_valid_a}, 32'h0);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        tick();
        check("s33.pc12", out_pc_a, 32'd12);
        check("s33.instr12", out_instr_a, 32'h00A2_40B3);
        tick();
        check("s33.pc16", out_pc_a, 32'd16);

        // Misaligned redirect.
        redirect_valid = 1'b1;
        redirect_pc    = 32'd6;
        tick();
        check("s35.valid", {31'b0, out_valid_a}, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("s35.fault", {31'b0, fault_a}, 32'h1);
        redirect_pc = 32'd8;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        check("s35.fault_sticky", {31'b0, fault_a}, 32'h1);
        check("s35.valid_low", {31'b0, out_valid_a}, 32'h0);
`else
        check("s35.nofault", {31'b0, fault_a}, 32'h0);
        redirect_valid = 1'b0;
        tick();
        check("s35.pc4", out_pc_a, 32'h4);
        check("s35.instr4", out_instr_a, 32'h00A2_00B3);
`endif

        // Reset during a stall with a pending redirect.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        out_ready = 1'b0;
        tick();
        check("s36.stalled", {31'b0, out_valid_a}, 32'h1);
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd40;
        tick();
        check("s36.valid", {31'b0, out_valid_a}, 32'h0);
        check("s36.pc", imem_addr_a, 32'h0);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 99) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = 32'($urandom_range(0, 255)) * 4;
            if ($urandom_range(0, 7) == 0) redirect_pc = redirect_pc + 32'($urandom_range(1, 3));
            out_ready      = ($urandom_range(0, 9) < 7);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
